univ_reg: RTL

Parametrised universal register: a WIDTH-bit, positive-edge, synchronously reset register with enable and eight operating modes (hold, load, logical shifts, rotates, increment, decrement). It generalises the single-bit D flip-flop into the lab's reusable state element for datapath and counter work. It also provides a registered carry/shift-out flag and a combinational zero flag.

---
 rtl/univ_reg_if.sv | 23 ++
 rtl/univ_reg.sv | 94 +++++++++
 2 files changed

// File: rtl/univ_reg_if.sv
// Control and data bundle for univ_reg: the master drives en/op/d/sin; the register returns q/carry/zero.
// No handshake. en is the only qualifier, and the register never stalls its driver.
interface univ_reg_if #(
    parameter int p_nbits = 8
);
    logic               en;
    logic [2:0]         op;
    logic [p_nbits-1:0] d;
    logic               sin;
    logic [p_nbits-1:0] q;
    logic               carry;
    logic               zero;

    modport master (
        output en, op, d, sin,
        input  q, carry, zero
    );

    modport slave (
        input  en, op, d, sin,
        output q, carry, zero
    );
endinterface

// File: rtl/univ_reg.sv
// Universal register: hold/load/shift/rotate/inc/dec with a registered carry and a combinational zero flag.
// Latency: 1 cycle. Backpressure: none; en=0 freezes q and carry.
module univ_reg #(
    parameter int                 p_nbits       = 8,
    parameter logic [p_nbits-1:0] p_reset_value = '0
) (
    input  logic      clk,
    input  logic      rst,
    univ_reg_if.slave bus
);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101,
        OP_INC  = 3'b110,
        OP_DEC  = 3'b111
    } op_e;

    logic [p_nbits-1:0] q_q, q_d;
    logic               carry_q, carry_d;
    logic [p_nbits:0]   inc_sum;
    logic [p_nbits:0]   dec_diff;
    op_e                op_sel;

    assign op_sel = op_e'(bus.op);

    // The extra MSB of the widened arithmetic supplies the wrap carry and borrow.
    assign inc_sum  = {1'b0, q_q} + {{p_nbits{1'b0}}, 1'b1};
    assign dec_diff = {1'b0, q_q} - {{p_nbits{1'b0}}, 1'b1};

    always_comb begin
        q_d     = q_q;
        carry_d = carry_q;
        if (bus.en) begin
            case (op_sel)
                OP_HOLD: begin
                    q_d     = q_q;
                    carry_d = carry_q;
                end
                OP_LOAD: begin
                    q_d     = bus.d;
                    carry_d = 1'b0;
                end
                OP_SHL: begin
                    q_d     = {q_q[p_nbits-2:0], bus.sin};
                    carry_d = q_q[p_nbits-1];
                end
                OP_SHR: begin
                    q_d     = {bus.sin, q_q[p_nbits-1:1]};
                    carry_d = q_q[0];
                end
                OP_ROL: begin
                    q_d     = {q_q[p_nbits-2:0], q_q[p_nbits-1]};
                    carry_d = q_q[p_nbits-1];
                end
                OP_ROR: begin
                    q_d     = {q_q[0], q_q[p_nbits-1:1]};
                    carry_d = q_q[0];
                end
                OP_INC: begin
                    q_d     = inc_sum[p_nbits-1:0];
                    carry_d = inc_sum[p_nbits];
                end
                OP_DEC: begin
                    q_d     = dec_diff[p_nbits-1:0];
                    carry_d = dec_diff[p_nbits];
                end
                default: begin
                    q_d     = q_q;
                    carry_d = carry_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q     <= p_reset_value;
            carry_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            carry_q <= carry_d;
        end
    end

    assign bus.q     = q_q;
    assign bus.carry = carry_q;
    assign bus.zero  = (q_q == '0);

endmodule
